// File: rtl/out_stream_arbiter_if.sv
// Stream bundle around the result arbiter: NUM_IN packed input channels in, one tagged stream out.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface out_stream_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int OUTW   = 24
);
  localparam int IDW = $clog2(NUM_IN);

  logic [NUM_IN*OUTW-1:0] IN_AXIS_TDATA;
  logic [NUM_IN-1:0]      IN_AXIS_TVALID;
  logic [NUM_IN-1:0]      IN_AXIS_TREADY;
  logic [OUTW-1:0]        OUT_AXIS_TDATA;
  logic [IDW-1:0]         OUT_AXIS_TID;
  logic                   OUT_AXIS_TLAST;
  logic                   OUT_AXIS_TVALID;
  logic                   OUT_AXIS_TREADY;

  modport slave (
    input  IN_AXIS_TDATA, IN_AXIS_TVALID, OUT_AXIS_TREADY,
    output IN_AXIS_TREADY, OUT_AXIS_TDATA, OUT_AXIS_TID, OUT_AXIS_TLAST, OUT_AXIS_TVALID
  );

  modport master (
    output IN_AXIS_TDATA, IN_AXIS_TVALID, OUT_AXIS_TREADY,
    input  IN_AXIS_TREADY, OUT_AXIS_TDATA, OUT_AXIS_TID, OUT_AXIS_TLAST, OUT_AXIS_TVALID
  );
endinterface

// File: rtl/out_stream_arbiter.sv
// Round-robin burst arbiter merging NUM_IN streams into one; 1-cycle latency through a single output register.
// Backpressure: input ready follows out_free of the granted channel only; output holds stable while stalled.
module out_stream_arbiter #(
  parameter int NUM_IN = 4,
  parameter int OUTW   = 24,
  parameter int BURST  = 8
) (
  input  logic                clk,
  input  logic                reset,
  out_stream_arbiter_if.slave axis
);
  localparam int IDW = $clog2(NUM_IN);
  localparam int CW  = $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  typedef struct packed {
    logic [OUTW-1:0] dat;
    logic [IDW-1:0]  id;
    logic            last;
  } beat_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] grant, grant_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;
  logic [IDW-1:0] pick;
  logic [IDW:0]   rr_idx;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           pick_vld;
  logic           out_vld;
  logic           out_free;
  logic           accept;
  beat_t          out_beat;
  beat_t          in_beat;

  // Scan from last_grant+1 upward; the extra index bit lets the wrap work for any NUM_IN.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_grant;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_idx = {1'b0, last_grant} + (IDW+1)'(k);
      if (rr_idx >= (IDW+1)'(NUM_IN)) rr_idx = rr_idx - (IDW+1)'(NUM_IN);
      if (!pick_vld && axis.IN_AXIS_TVALID[rr_idx[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_idx[IDW-1:0];
      end
    end
  end

  assign out_free = !out_vld || axis.OUT_AXIS_TREADY;
  assign accept   = (state == S_GRANT) && !reset && axis.IN_AXIS_TVALID[grant] && out_free;

  always_comb begin
    axis.IN_AXIS_TREADY = '0;
    if (state == S_GRANT && !reset) axis.IN_AXIS_TREADY[grant] = out_free;
  end

  always_comb begin
    in_beat      = '0;
    in_beat.dat  = axis.IN_AXIS_TDATA[grant*OUTW +: OUTW];
    in_beat.id   = grant;
    in_beat.last = (cnt == CNT_LAST);
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt = S_GRANT;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        // The grant is never preempted; a stalled channel simply holds the arbiter.
        if (accept) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt        = '0;
            last_grant_nxt = grant;
            state_nxt      = S_IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= IDW'(NUM_IN - 1);
      cnt        <= '0;
      out_vld    <= 1'b0;
      out_beat   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      if (accept) begin
        out_vld  <= 1'b1;
        out_beat <= in_beat;
      end else if (axis.OUT_AXIS_TREADY) begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign axis.OUT_AXIS_TVALID = out_vld;
  assign axis.OUT_AXIS_TDATA  = out_beat.dat;
  assign axis.OUT_AXIS_TID    = out_beat.id;
  assign axis.OUT_AXIS_TLAST  = out_beat.last;

endmodule

// File: tb/tb_out_stream_arbiter.sv
// Bench for out_stream_arbiter: vector table, directed burst sequences and a random run under a reference monitor.
// Inputs change 1ns after the rising edge; everything is observed on the falling edge.
module tb_out_stream_arbiter;
  localparam int NUM_IN = 4;
  localparam int OUTW   = 24;
  localparam int BURST  = 8;
  localparam int IDW    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  out_stream_arbiter_if #(.NUM_IN(NUM_IN), .OUTW(OUTW)) bus ();

  out_stream_arbiter #(.NUM_IN(NUM_IN), .OUTW(OUTW), .BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .axis  (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ovld;
    logic [1:0] e_tid;
    logic       e_last;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int n_beats = 0;
  int n_tlast = 0;
  int burst_q[$];
  logic [15:0]       src_cnt [NUM_IN];
  logic [NUM_IN-1:0] last_hs = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NUM_IN-1:0] v);
    for (int k = 1; k <= NUM_IN; k++)
      if (v[(last + k) % NUM_IN]) return (last + k) % NUM_IN;
    return -1;
  endfunction

  // Reference: transaction view of the arbiter (idle/granted, beats left in the burst, round-robin pointer).
  initial begin : monitor
    logic armed, p_reset, p_ovld, p_ordy, p_last, m_idle;
    logic [NUM_IN-1:0]      p_vld, p_rdy, hs, exp_rdy;
    logic [NUM_IN*OUTW-1:0] p_in;
    logic [OUTW-1:0]        p_dat;
    logic [IDW-1:0]         p_id;
    int m_last, m_grant, m_cnt, ch;
    armed = 1'b0; m_idle = 1'b1; m_last = NUM_IN - 1; m_grant = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (p_reset) begin
          chk("rst_ovld", bus.OUT_AXIS_TVALID, 0);
          chk("rst_tlast", bus.OUT_AXIS_TLAST, 0);
          chk("rst_tdata", bus.OUT_AXIS_TDATA, 0);
          chk("rst_tid", bus.OUT_AXIS_TID, 0);
          m_idle = 1'b1; m_last = NUM_IN - 1; m_cnt = 0;
        end else begin
          hs = p_vld & p_rdy;
          if (hs != '0) begin
            ch = 0;
            for (int c = NUM_IN - 1; c >= 0; c--) if (hs[c]) ch = c;
            chk("beat_ovld", bus.OUT_AXIS_TVALID, 1);
            chk("beat_data", bus.OUT_AXIS_TDATA, p_in[ch*OUTW +: OUTW]);
            chk("beat_tid", bus.OUT_AXIS_TID, ch);
            chk("beat_tlast", bus.OUT_AXIS_TLAST, (m_cnt == BURST - 1));
            chk("beat_src", ch, m_grant);
            if (m_cnt == 0) burst_q.push_back(ch);
            n_beats++;
            if (bus.OUT_AXIS_TLAST) n_tlast++;
            m_cnt++;
            if (m_cnt == BURST) begin
              m_cnt = 0; m_last = m_grant; m_idle = 1'b1;
            end
          end else if (p_ovld && !p_ordy) begin
            chk("hold_ovld", bus.OUT_AXIS_TVALID, 1);
            chk("hold_data", bus.OUT_AXIS_TDATA, p_dat);
            chk("hold_tid", bus.OUT_AXIS_TID, p_id);
            chk("hold_tlast", bus.OUT_AXIS_TLAST, p_last);
          end else begin
            chk("drain_ovld", bus.OUT_AXIS_TVALID, 0);
          end
        end
        exp_rdy = '0;
        if (!reset && !m_idle && (!bus.OUT_AXIS_TVALID || bus.OUT_AXIS_TREADY)) exp_rdy[m_grant] = 1'b1;
        chk("in_ready", bus.IN_AXIS_TREADY, exp_rdy);
        if (!reset && m_idle && bus.IN_AXIS_TVALID != '0) begin
          m_grant = rr_pick(m_last, bus.IN_AXIS_TVALID);
          m_idle  = 1'b0;
        end
      end
      armed   = 1'b1;
      p_reset = reset;
      p_vld   = bus.IN_AXIS_TVALID;
      p_rdy   = bus.IN_AXIS_TREADY;
      p_in    = bus.IN_AXIS_TDATA;
      p_ovld  = bus.OUT_AXIS_TVALID;
      p_ordy  = bus.OUT_AXIS_TREADY;
      p_dat   = bus.OUT_AXIS_TDATA;
      p_id    = bus.OUT_AXIS_TID;
      p_last  = bus.OUT_AXIS_TLAST;
      last_hs = bus.IN_AXIS_TVALID & bus.IN_AXIS_TREADY & {NUM_IN{!reset}};
    end
  end

  // One clock: sources advance on the handshake just taken, new inputs are applied, then wait to the observe point.
  task automatic step(input logic r, input logic [NUM_IN-1:0] v, input logic o);
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_IN; c++) begin
      if (last_hs[c]) src_cnt[c] = src_cnt[c] + 16'd1;
      bus.IN_AXIS_TDATA[c*OUTW +: OUTW] = {8'(c), src_cnt[c]};
    end
    reset               = r;
    bus.IN_AXIS_TVALID  = v;
    bus.OUT_AXIS_TREADY = o;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_beats = 0;
    n_tlast = 0;
    burst_q.delete();
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b1);
    clear_stats();
  endtask

  task automatic run_until(input logic [NUM_IN-1:0] v, input int target, input int max_cyc, input string nm);
    int c;
    c = 0;
    while (n_beats < target && c < max_cyc) begin
      step(1'b0, v, 1'b1);
      c++;
    end
    chk({nm, "_reached"}, (n_beats >= target), 1);
  endtask

  initial begin : stim
    vec_t tbl [20];
    int   cyc, bubbles;
    logic [OUTW-1:0] exp_dat;

    reset = 1'b1;
    bus.IN_AXIS_TVALID  = '0;
    bus.OUT_AXIS_TREADY = 1'b1;
    for (int c = 0; c < NUM_IN; c++) begin
      src_cnt[c] = 16'd0;
      bus.IN_AXIS_TDATA[c*OUTW +: OUTW] = {8'(c), 16'd0};
    end
    step(1'b1, '0, 1'b1);
    step(1'b1, '0, 1'b1);

    // rst, vld, ordy | ready, ovld, tid, tlast
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'h8, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
    tbl[17] = '{1'b0, 4'h8, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[19] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0};
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].ordy);
      chk($sformatf("tbl%0d_ready", i), bus.IN_AXIS_TREADY, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ovld", i), bus.OUT_AXIS_TVALID, tbl[i].e_ovld);
      if (tbl[i].e_ovld) begin
        chk($sformatf("tbl%0d_tid", i), bus.OUT_AXIS_TID, tbl[i].e_tid);
        chk($sformatf("tbl%0d_tlast", i), bus.OUT_AXIS_TLAST, tbl[i].e_last);
      end
    end

    // All channels valid: four bursts rotate 0..3 with one bubble between bursts.
    do_reset();
    cyc = 0; bubbles = 0;
    while (n_beats < 32 && cyc < 60) begin
      step(1'b0, 4'hF, 1'b1);
      cyc++;
      if (n_beats > 0 && n_beats < 32 && !bus.OUT_AXIS_TVALID) bubbles++;
    end
    chk("rot_cycles", cyc, 37);
    chk("rot_bubbles", bubbles, 3);
    chk("rot_tlast", n_tlast, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rot_burst%0d", i), (burst_q.size() > i) ? burst_q[i] : -1, i);

    // Only channel 2 valid: re-granted back to back.
    do_reset();
    run_until(4'b0100, 16, 60, "solo");
    chk("solo_bursts", burst_q.size(), 2);
    chk("solo_tid0", (burst_q.size() > 0) ? burst_q[0] : -1, 2);
    chk("solo_tid1", (burst_q.size() > 1) ? burst_q[1] : -1, 2);
    chk("solo_tlast", n_tlast, 2);

    // Output stalled for 5 cycles with beat 3 on the bus.
    do_reset();
    run_until(4'hF, 2, 20, "bp");
    exp_dat = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'hF, 1'b0);
      if (i == 0) exp_dat = {8'd0, 16'(src_cnt[0] - 16'd1)};
      chk($sformatf("bp_hold%0d_data", i), bus.OUT_AXIS_TDATA, exp_dat);
      chk($sformatf("bp_hold%0d_ready", i), bus.IN_AXIS_TREADY, 4'h0);
      chk($sformatf("bp_hold%0d_beats", i), n_beats, 3);
    end
    run_until(4'hF, 8, 20, "bp_rest");
    chk("bp_tlast", n_tlast, 1);
    chk("bp_src", (burst_q.size() > 0) ? burst_q[0] : -1, 0);

    // Granted channel 1 stalls after beat 4 while channel 3 waits.
    do_reset();
    run_until(4'b1010, 3, 20, "stall");
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1000, 1'b1);
    chk("stall_beats", n_beats, 4);
    chk("stall_ready", bus.IN_AXIS_TREADY, 4'b0010);
    run_until(4'b1010, 16, 60, "stall_rest");
    chk("stall_burst0", (burst_q.size() > 0) ? burst_q[0] : -1, 1);
    chk("stall_burst1", (burst_q.size() > 1) ? burst_q[1] : -1, 3);

    // Reset in the middle of channel 1's burst restarts arbitration at channel 0.
    do_reset();
    run_until(4'hF, 13, 40, "mid");
    step(1'b1, 4'hF, 1'b1);
    chk("mid_rst_ready", bus.IN_AXIS_TREADY, 4'h0);
    clear_stats();
    step(1'b0, 4'hF, 1'b1);
    chk("mid_ovld", bus.OUT_AXIS_TVALID, 0);
    chk("mid_tdata", bus.OUT_AXIS_TDATA, 0);
    run_until(4'hF, 8, 20, "mid_rest");
    chk("mid_restart", (burst_q.size() > 0) ? burst_q[0] : -1, 0);

    // Random valids, backpressure and occasional resets under the monitor.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
